axil_reg_bank: RTL and testbench
================================

AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: AXI-lite data width in bits.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 8: AXI-lite address width in bits.
- REQ-003 SHALL have parameter NUM_REGS, default 16: register count (minimum 4).
- REQ-004 SHALL have these ports:
  - clk  in  1  sole clock.
  - rst_n  in  1  reset, asynchronous, active-low.
  - s_axil_awaddr  in  ADDR_WIDTH  write address.
  - s_axil_awvalid  in  1 / s_axil_awready  out  1.
  - s_axil_wdata  in  DATA_WIDTH  write data.
  - s_axil_wstrb  in  DATA_WIDTH/8  byte enable.
  - s_axil_wvalid  in  1 / s_axil_wready  out  1.
  - s_axil_bresp  out  2 / s_axil_bvalid  out  1 / s_axil_bready  in  1.
  - s_axil_araddr  in  ADDR_WIDTH  read address.
  - s_axil_arvalid  in  1 / s_axil_arready  out  1.
  - s_axil_rdata  out  DATA_WIDTH / s_axil_rresp  out  2 / s_axil_rvalid  out  1 / s_axil_rready  in  1.
  - cfg_regs  out  (NUM_REGS-2)*DATA_WIDTH  active config, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH].
  - status_i  in  DATA_WIDTH  live status, readable at NUM_REGS-1.
  - start_pulse  out  1  one-cycle trigger.
  - cfg_wr  out  1  one-cycle strobe on any accepted config write.

Function
- REQ-005 SHALL use this map: 0..NUM_REGS-3 RW config; NUM_REGS-2 CTRL (bit0 start, bit1 commit; write-only, reads 0); NUM_REGS-1 STATUS (RO, writes ignored, OKAY).
- REQ-006 Write FSM SHALL have states W_IDLE and W_RESP.
- REQ-007 In W_IDLE with awvalid and wvalid both high, awready and wready SHALL be high for exactly that cycle; the register SHALL update on that edge; the FSM SHALL go to W_RESP.
- REQ-008 In W_RESP, bvalid SHALL be high and held until bready; then back to W_IDLE. awready and wready SHALL stay low in W_RESP.
- REQ-009 awvalid without wvalid (or the reverse) SHALL NOT be accepted; the master waits until both are high.
- REQ-010 A write SHALL take effect only when wstrb[0]=1; with wstrb=0 the handshake completes and no state changes.
- REQ-011 Address >= NUM_REGS: write ignored, bresp=2'b10 (SLVERR); read returns rdata=0, rresp=2'b10. All other responses 2'b00.
- REQ-012 Read FSM SHALL have states R_IDLE and R_DATA. arready is high in R_IDLE; on handshake rdata is registered and the FSM goes to R_DATA with rvalid=1 the next cycle. rvalid and rdata SHALL hold until rready.
- REQ-013 Read and write FSMs SHALL be independent. A read and a write handshaking in the same cycle at the same address SHALL return the pre-write value.
- REQ-014 A CTRL write with bit0=1 SHALL assert start_pulse for exactly one cycle, the cycle after the write handshake.
- REQ-015 cfg_wr SHALL pulse one cycle after each effective config-address write.
- REQ-016 STATUS reads SHALL sample status_i in the arready cycle.

Reset
- REQ-017 While rst_n=0: all registers 0, cfg_regs=0, FSMs idle, bvalid/rvalid/start_pulse/cfg_wr=0, awready/wready=0, arready=0.
- REQ-018 Reset asserted mid-transaction SHALL abort it; there is no response after release.
- REQ-019 arready SHALL go high on the first clk edge after rst_n rises.

Configuration
- REQ-020 With REG_SHADOW_EN defined: config writes go to shadow registers; reads return shadow values; a CTRL bit1 write SHALL copy all shadows to cfg_regs in one cycle (visible the cycle after the handshake). cfg_wr SHALL pulse on commit only.
- REQ-021 Without REG_SHADOW_EN: writes update cfg_regs directly, CTRL bit1 is ignored, and cfg_wr follows REQ-015.

Structure
- REQ-022 Package axil_reg_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, the CTRL bit indices, and the FSM state encodings.
- REQ-023 The block SHALL be a single module; no sub-module.

Verification
- REQ-024 Write 0x5A to addr 0x03 with aw and w in the same cycle -> bresp=00 one cycle later; readback 0x5A; cfg_regs[31:24]=0x5A (no shadow).
- REQ-025 awvalid 3 cycles before wvalid -> awready stays low until wvalid; a single update; bvalid held for 4 cycles while bready=0.
- REQ-026 Write addr 0x20 -> bresp=10, no register change; read 0x20 -> rdata=0, rresp=10.
- REQ-027 CTRL write 0x01 -> start_pulse high for exactly 1 cycle; read CTRL -> 0x00; status_i=0xA5 -> STATUS read 0xA5.
- REQ-028 REG_SHADOW_EN: write 0x11 to addr 0 -> cfg_regs unchanged; CTRL write 0x02 -> cfg_regs[7:0]=0x11 the next cycle and cfg_wr pulses.
- REQ-029 Drop rst_n while in W_RESP -> bvalid=0 immediately; registers 0; no response after release.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// Shared constants for the AXI-lite register bank: response codes, CTRL bit
// positions and the write/read FSM state encodings.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_COMMIT_BIT = 1;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_reg_bank.sv
// AXI-lite register bank: config registers, write-only CTRL, read-only STATUS.
// Optional REG_SHADOW_EN stages config writes in shadows until a CTRL commit.
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
    input  logic                             s_axil_awvalid,
    output logic                             s_axil_awready,
    input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]          s_axil_wstrb,
    input  logic                             s_axil_wvalid,
    output logic                             s_axil_wready,
    output logic [1:0]                       s_axil_bresp,
    output logic                             s_axil_bvalid,
    input  logic                             s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
    input  logic                             s_axil_arvalid,
    output logic                             s_axil_arready,
    output logic [DATA_WIDTH-1:0]            s_axil_rdata,
    output logic [1:0]                       s_axil_rresp,
    output logic                             s_axil_rvalid,
    input  logic                             s_axil_rready,
    output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] cfg_regs,
    input  logic [DATA_WIDTH-1:0]            status_i,
    output logic                             start_pulse,
    output logic                             cfg_wr
);

    localparam int NUM_CFG = NUM_REGS - 2;
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(NUM_REGS - 2);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    // Holds the ready outputs low until the first edge after reset release.
    logic en_q;

    logic [NUM_CFG-1:0][DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic [NUM_CFG-1:0][DATA_WIDTH-1:0] rd_src_s;
`ifdef REG_SHADOW_EN
    logic [NUM_CFG-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
`endif

    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  start_q, start_d;
    logic                  cfg_wr_q, cfg_wr_d;

    logic                  aw_hs_s;
    logic                  ar_hs_s;
    logic                  wr_en_s;
    logic                  wr_cfg_s;
    logic                  wr_ctrl_s;
    logic                  wr_err_s;
    logic [DATA_WIDTH-1:0] rd_val_s;
    logic                  rd_err_s;

    assign aw_hs_s   = en_q && (w_state_q == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign ar_hs_s   = en_q && (r_state_q == R_IDLE) && s_axil_arvalid;
    assign wr_err_s  = (s_axil_awaddr > STATUS_ADDR);
    assign wr_en_s   = aw_hs_s && s_axil_wstrb[0];
    assign wr_cfg_s  = wr_en_s && (s_axil_awaddr < CTRL_ADDR);
    assign wr_ctrl_s = wr_en_s && (s_axil_awaddr == CTRL_ADDR);

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            en_q      <= 1'b0;
            cfg_q     <= '0;
`ifdef REG_SHADOW_EN
            shadow_q  <= '0;
`endif
            bresp_q   <= 2'b00;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            start_q   <= 1'b0;
            cfg_wr_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            en_q      <= 1'b1;
            cfg_q     <= cfg_d;
`ifdef REG_SHADOW_EN
            shadow_q  <= shadow_d;
`endif
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            start_q   <= start_d;
            cfg_wr_q  <= cfg_wr_d;
        end
    end

    // Write FSM next state.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  w_state_d = aw_hs_s ? W_RESP : W_IDLE;
            W_RESP:  w_state_d = s_axil_bready ? W_IDLE : W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write datapath: register updates, response code and one-cycle strobes.
    always_comb begin
        bresp_d = aw_hs_s ? (wr_err_s ? RESP_SLVERR : RESP_OKAY) : bresp_q;
        start_d = wr_ctrl_s && s_axil_wdata[CTRL_START_BIT];
`ifdef REG_SHADOW_EN
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_CFG; k++) begin
            shadow_d[k] = (wr_cfg_s && (s_axil_awaddr == ADDR_WIDTH'(k))) ? s_axil_wdata : shadow_q[k];
        end
        cfg_wr_d = wr_ctrl_s && s_axil_wdata[CTRL_COMMIT_BIT];
        cfg_d    = cfg_wr_d ? shadow_q : cfg_q;
`else
        cfg_d = cfg_q;
        for (int k = 0; k < NUM_CFG; k++) begin
            cfg_d[k] = (wr_cfg_s && (s_axil_awaddr == ADDR_WIDTH'(k))) ? s_axil_wdata : cfg_q[k];
        end
        cfg_wr_d = wr_cfg_s;
`endif
    end

    // Read source: shadows when staging is enabled, otherwise the live config.
    always_comb begin
`ifdef REG_SHADOW_EN
        rd_src_s = shadow_q;
`else
        rd_src_s = cfg_q;
`endif
    end

    // Read address decode; CTRL falls through to zero.
    always_comb begin
        rd_err_s = (s_axil_araddr > STATUS_ADDR);
        rd_val_s = (s_axil_araddr == STATUS_ADDR) ? status_i : '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            rd_val_s = rd_val_s | (rd_src_s[k] & {DATA_WIDTH{s_axil_araddr == ADDR_WIDTH'(k)}});
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  r_state_d = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_d = s_axil_rready ? R_IDLE : R_DATA;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data capture; sampled before any same-cycle write lands.
    always_comb begin
        rdata_d = ar_hs_s ? (rd_err_s ? '0 : rd_val_s) : rdata_q;
        rresp_d = ar_hs_s ? (rd_err_s ? RESP_SLVERR : RESP_OKAY) : rresp_q;
    end

    // Handshake outputs decoded from FSM state.
    always_comb begin
        s_axil_awready = aw_hs_s;
        s_axil_wready  = aw_hs_s;
        s_axil_bvalid  = (w_state_q == W_RESP);
        s_axil_arready = en_q && (r_state_q == R_IDLE);
        s_axil_rvalid  = (r_state_q == R_DATA);
    end

    assign s_axil_bresp = bresp_q;
    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = rresp_q;
    assign cfg_regs     = cfg_q;
    assign start_pulse  = start_q;
    assign cfg_wr       = cfg_wr_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (default parameters).
module tb_axil_reg_bank;
    import axil_reg_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam int CW = (NR - 2) * DW;
`ifdef REG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata, status_i;
    logic [0:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [CW-1:0] cfg_regs;
    logic          start_pulse, cfg_wr;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] exp_cfg;
    logic [CW-1:0] exp_shd;

    axil_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .cfg_regs(cfg_regs), .status_i(status_i), .start_pulse(start_pulse), .cfg_wr(cfg_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input int a, input logic [7:0] d);
        exp_shd[a*DW +: DW] = d;
        if (!SHADOW) exp_cfg[a*DW +: DW] = d;
    endtask

    // Entered and left at posedge+1.
    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic s,
                      input logic [1:0] resp, input logic cw, input logic sp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        chk("awready", awready, 1'b1);
        chk("wready", wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, resp);
        chk("cfg_wr", cfg_wr, cw);
        chk("start_pulse", start_pulse, sp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_clr", bvalid, 1'b0);
        chk("cfg_wr_off", cfg_wr, 1'b0);
        chk("start_off", start_pulse, 1'b0);
        tick();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic [1:0] resp);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, d);
        chk("rresp", rresp, resp);
        tick();
        @(negedge clk);
        chk("rvalid_hold", rvalid, 1'b1);
        chk("rdata_hold", rdata, d);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_clr", rvalid, 1'b0);
        tick();
    endtask

    initial begin
        exp_cfg = '0; exp_shd = '0;
        rst_n = 1'b0; bready = 1'b0; rready = 1'b0; status_i = 8'h00;
        awaddr = 8'h03; wdata = 8'hEE; wstrb = 1'b1; araddr = 8'h03;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_cfg", cfg_regs, '0);
        chk("rst_start", start_pulse, 1'b0);
        chk("rst_cfg_wr", cfg_wr, 1'b0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arready_pre_edge", arready, 1'b0);
        tick();
        chk("arready_first_edge", arready, 1'b1);

        // Basic write and readback
        wr(8'h03, 8'h5A, 1'b1, RESP_OKAY, !SHADOW, 1'b0);
        model_wr(3, 8'h5A);
        chk("cfg_after_wr3", cfg_regs, exp_cfg);
        rd(8'h03, 8'h5A, RESP_OKAY);

        // Address arrives three cycles ahead of data
        awaddr = 8'h05; wdata = 8'hC3; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_wait_awready", awready, 1'b0);
            chk("aw_wait_wready", wready, 1'b0);
            tick();
        end
        wvalid = 1'b1;
        @(negedge clk);
        chk("aw_late_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_wr(5, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("awready_in_resp", awready, 1'b0);
            if (i == 0) chk("cfg_wr_once", cfg_wr, !SHADOW);
            else        chk("cfg_wr_low", cfg_wr, 1'b0);
            tick();
        end
        bready = 1'b1;
        @(negedge clk);
        chk("bvalid_last", bvalid, 1'b1);
        tick();
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_done", bvalid, 1'b0);
        chk("cfg_after_wr5", cfg_regs, exp_cfg);
        tick();

        // Out-of-range address
        wr(8'h20, 8'h77, 1'b1, RESP_SLVERR, 1'b0, 1'b0);
        chk("cfg_after_oor", cfg_regs, exp_cfg);
        rd(8'h20, 8'h00, RESP_SLVERR);

        // Zero strobe: handshake completes, nothing changes
        wr(8'h01, 8'hFF, 1'b0, RESP_OKAY, 1'b0, 1'b0);
        chk("cfg_after_strb0", cfg_regs, exp_cfg);
        rd(8'h01, 8'h00, RESP_OKAY);

        // CTRL start, CTRL readback, STATUS read and ignored STATUS write
        wr(8'h0E, 8'h01, 1'b1, RESP_OKAY, 1'b0, 1'b1);
        rd(8'h0E, 8'h00, RESP_OKAY);
        status_i = 8'hA5;
        rd(8'h0F, 8'hA5, RESP_OKAY);
        wr(8'h0F, 8'h33, 1'b1, RESP_OKAY, 1'b0, 1'b0);
        status_i = 8'h3C;
        rd(8'h0F, 8'h3C, RESP_OKAY);
        chk("cfg_after_ctrl", cfg_regs, exp_cfg);

        // Same-cycle read and write to one address returns the old value
        awaddr = 8'h03; wdata = 8'h96; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h03; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        chk("both_awready", awready, 1'b1);
        chk("both_arready", arready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_wr(3, 8'h96);
        @(negedge clk);
        chk("both_rvalid", rvalid, 1'b1);
        chk("both_rdata_old", rdata, 8'h5A);
        chk("both_bvalid", bvalid, 1'b1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        chk("both_bvalid_clr", bvalid, 1'b0);
        chk("both_rvalid_clr", rvalid, 1'b0);
        tick();
        rd(8'h03, 8'h96, RESP_OKAY);

        // Config write to reg 0, then CTRL commit
        wr(8'h00, 8'h11, 1'b1, RESP_OKAY, !SHADOW, 1'b0);
        model_wr(0, 8'h11);
        chk("cfg_before_commit", cfg_regs, exp_cfg);
        rd(8'h00, 8'h11, RESP_OKAY);
        wr(8'h0E, 8'h02, 1'b1, RESP_OKAY, SHADOW, 1'b0);
        exp_cfg = exp_shd;
        chk("cfg_after_commit", cfg_regs, exp_cfg);
        chk("cfg0_after_commit", cfg_regs[7:0], 8'h11);

        // Reset while in W_RESP
        awaddr = 8'h02; wdata = 8'h44; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        chk("abort_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("abort_bvalid_pre", bvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bvalid", bvalid, 1'b0);
        chk("abort_cfg", cfg_regs, '0);
        chk("abort_arready", arready, 1'b0);
        exp_cfg = '0; exp_shd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", bvalid, 1'b0);
            tick();
        end
        rd(8'h02, 8'h00, RESP_OKAY);
        rd(8'h03, 8'h00, RESP_OKAY);
        chk("cfg_after_abort", cfg_regs, exp_cfg);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
